dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit sitting between the pipeline MEM stage and port A of the dual-port data RAM (word-addressed, 4-bit byte write enables, 1-cycle registered read). Converts byte/half/word loads and stores into RAM word accesses with byte-lane masks, sign/zero-extends load data, and splits word-crossing accesses into two RAM cycles. Port B of the RAM is left to the debug/loader path.

## Interface
- No parameters; address width fixed at 32, RAM word address 30 bits ([31:2]).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM stage has an access
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use [1:0])
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data, valid with resp_valid (0 for stores)
- misalign_fault  out  1  pulses with resp_valid on a rejected crossing access
- ram_we  out  4  byte write enables to RAM port A
- ram_addr  out  30  word address to RAM port A
- ram_din  out  32  lane-shifted write data
- ram_dout  in  32  RAM port A read data (valid 1 cycle after address sampled)

## Operation
- States: IDLE, LD_WAIT, LD_HI, LD_MRG, ST_HI.
- Acceptance edge E0 = rising edge with req_valid && req_ready. In IDLE ram_addr/ram_we/ram_din are driven combinationally from the request, so the RAM samples at E0; ram_we=0 when req_valid=0.
- Offset o = req_addr[1:0]. Crossing access: W with o!=0, H with o=3. All others (incl. H at o=1) use one word.
- Lane masks: B → 4'b0001<<o; H → 4'b0011<<o; W → 4'b1111<<o; bits shifted past lane 3 form the high-word mask (low 4 bits of mask>>4). ram_din = wdata<<(8*o), high-word data = wdata>>(8*(4-o)).
- Aligned/non-crossing store: write at E0, → IDLE; resp_valid next cycle.
- Non-crossing load: → LD_WAIT; next edge extracts bytes from ram_dout>>(8*o), extends per funct3 into resp_rdata, resp_valid next cycle.
- Crossing load: E0 reads low word → LD_HI drives ram_addr+1, captures low word at E1 → LD_MRG; at E2 merges {hi,lo}>>(8*o), extends, resp_valid after E2.
- Crossing store: E0 writes low lanes → ST_HI writes high lanes at ram_addr+1 (E1) → IDLE, resp_valid after E1.
- ram_addr+1 wraps 30'h3FFFFFFF → 0. RAM range checking is the RAM's job.
- resp_valid cycle is in IDLE: a new request may be accepted in that same cycle.

## Timing
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, misalign_fault=0; ram_we=0 while rst high.
- Latency (E0 to resp_valid high): store 1, crossing store 2, load 2, crossing load 3 cycles.
- Throughput: one access per latency; req_ready=0 in all non-IDLE states.
- Reset mid-operation: return to IDLE, no response; a crossing store's already-written low half stays written.
- req_* need only be valid at E0; unit holds a registered copy.

## Configuration
- DMEM_LSU_MISALIGN_SPLIT_EN defined: crossing accesses split as above.
- Undefined: crossing accesses never touch RAM (ram_we=0), resp_valid + misalign_fault pulse 1 cycle after E0, resp_rdata=0; LD_HI/LD_MRG/ST_HI not built.

## Structure
- Package dmem_lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, lane-mask function.
- Sub-module lsu_lane_align: combinational byte shift + sign/zero extension for load data.

## Test plan
- SW 0x11223344 @0x10, then LW @0x10 → RAM word 4 = 0x11223344, resp_rdata=0x11223344 two cycles after E0.
- SB 0x80 @0x13, LB @0x13 → ram_we=4'b1000; resp_rdata=0xFFFFFF80; LBU → 0x00000080.
- SH 0xBEEF @0x21 (non-crossing) → ram_we=4'b0110; LHU @0x21 → 0x0000BEEF.
- With macro: SW 0xAABBCCDD @0x2E → word 0xB lanes 3:2 = CCDD, word 0xC lanes 1:0 = AABB; LW @0x2E → 0xAABBCCDD after 3 cycles.
- Without macro: LW @0x2E → misalign_fault=1, resp_rdata=0, no RAM write, 1-cycle latency.
- Assert rst in LD_HI → req_ready=1, resp_valid never pulses; next LW @0x10 completes normally.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the dmem_lsu load/store unit: funct3 encodings,
// FSM state encoding and the byte-lane mask helper.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LD_WAIT,
        LD_HI,
        LD_MRG,
        ST_HI
    } lsu_state_e;

    // Bits [3:0] are the lanes of the addressed word, bits [7:4] the lanes
    // that spill into the next word.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/dmem_lsu_lane_align.sv
// Load-data alignment: shifts the addressed bytes down to bit 0 and
// sign/zero-extends them according to funct3.
import dmem_lsu_pkg::*;

module lsu_lane_align (
    input  logic [63:0] data_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o
);

    logic [31:0] word;

    always_comb begin
        word = 32'(data_i >> {offset_i, 3'b000});
        case (funct3_i)
            F3_B:    rdata_o = {{24{word[7]}}, word[7:0]};
            F3_H:    rdata_o = {{16{word[15]}}, word[15:0]};
            F3_BU:   rdata_o = {24'h0, word[7:0]};
            F3_HU:   rdata_o = {16'h0, word[15:0]};
            default: rdata_o = word;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and RAM port A. Word-crossing
// accesses are split into two RAM cycles when DMEM_LSU_MISALIGN_SPLIT_EN is
// defined; otherwise they are rejected with misalign_fault.
import dmem_lsu_pkg::*;

module dmem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign_fault,
    output logic [3:0]  ram_we,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    lsu_state_e  state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        fault_q;

    logic [7:0]  mask_full;
    logic        crossing;
    logic [63:0] align_data;
    logic [31:0] align_rdata;

`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
    logic [29:0] addr_hi_q;
    logic [3:0]  we_hi_q;
    logic [31:0] din_hi_q;
    logic [31:0] lo_q;
    logic [31:0] din_hi;

    assign din_hi = 32'(({32'h0, req_wdata} << {req_addr[1:0], 3'b000}) >> 32);
`endif

    assign mask_full = lane_mask(req_funct3[1:0], req_addr[1:0]);
    assign crossing  = |mask_full[7:4];

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign misalign_fault = fault_q;

    // In IDLE the RAM port follows the request so the RAM samples it at E0.
    always_comb begin
        // NOTE: every output gets a default before the branches so no latch is inferred.
        ram_addr = req_addr[31:2];
        ram_din  = req_wdata << {req_addr[1:0], 3'b000};
        ram_we   = 4'b0000;
        if (state_q == IDLE && req_valid && req_we) begin
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
            ram_we = mask_full[3:0];
`else
            ram_we = crossing ? 4'b0000 : mask_full[3:0];
`endif
        end
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
        if (state_q == LD_HI) begin
            ram_addr = addr_hi_q;
        end
        if (state_q == ST_HI) begin
            ram_addr = addr_hi_q;
            ram_din  = din_hi_q;
            ram_we   = we_hi_q;
        end
`endif
        if (rst) begin
            ram_we = 4'b0000;
        end
    end

    always_comb begin
        align_data = {32'h0, ram_dout};
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
        if (state_q == LD_MRG) begin
            align_data = {ram_dout, lo_q};
        end
`endif
    end

    lsu_lane_align u_align (
        .data_i   (align_data),
        .offset_i (off_q),
        .funct3_i (funct3_q),
        .rdata_o  (align_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath copies are reset too; they are few flops and this
            // keeps simulation free of X on the response bus.
            state_q      <= IDLE;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            fault_q      <= 1'b0;
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
            addr_hi_q    <= 30'h0;
            we_hi_q      <= 4'b0000;
            din_hi_q     <= 32'h0;
            lo_q         <= 32'h0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        off_q    <= req_addr[1:0];
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
                        addr_hi_q <= req_addr[31:2] + 30'd1;
                        we_hi_q   <= mask_full[7:4];
                        din_hi_q  <= din_hi;
`endif
                        if (crossing) begin
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
                            state_q <= req_we ? ST_HI : LD_HI;
`else
                            resp_valid_q <= 1'b1;
                            fault_q      <= 1'b1;
                            resp_rdata_q <= 32'h0;
`endif
                        end else if (req_we) begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q <= LD_WAIT;
                        end
                    end
                end
                LD_WAIT: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= align_rdata;
                    state_q      <= IDLE;
                end
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
                LD_HI: begin
                    lo_q    <= ram_dout;
                    state_q <= LD_MRG;
                end
                LD_MRG: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= align_rdata;
                    state_q      <= IDLE;
                end
                ST_HI: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= 32'h0;
                    state_q      <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: vector table through a scoreboard, plus
// hand-written back-to-back, crossing and mid-operation reset sequences.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign_fault;
    logic [3:0]  ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    dmem_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .misalign_fault (misalign_fault),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout)
    );

    always #5 clk = ~clk;

    // Port-A RAM model: byte write enables, one-cycle registered read.
    logic [31:0] mem [0:63];
    int          wr_cnt = 0;
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= mem[ram_addr[5:0]];
        if (ram_we != 4'b0000) wr_cnt++;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_we;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          e0;
    } exp_t;

    exp_t sb[$];
    int   resp_cnt = 0;

    // Scoreboard consumer: every response pops the oldest expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_rdata"}, resp_rdata, e.rdata);
                check({e.name, "_fault"}, {31'h0, misalign_fault}, {31'h0, e.fault});
                check({e.name, "_lat"}, 32'(cyc - e.e0 + 1), 32'(e.lat));
            end
        end
    end

    function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] exp_we, input logic [31:0] exp_rdata,
                                input logic exp_fault, input int exp_lat);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_we = exp_we; v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Called #1 after a rising edge; returns #1 after the acceptance edge.
    task automatic issue(input vec_t v);
        exp_t e;
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        #1;
        for (int i = 0; i < 8 && !req_ready; i++) begin
            @(posedge clk);
            #2;
        end
        if (!req_ready) begin
            check({v.name, "_ready_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        check({v.name, "_ram_we"}, {28'h0, ram_we}, {28'h0, v.exp_we});
        e.name = v.name; e.rdata = v.exp_rdata; e.fault = v.exp_fault;
        e.lat = v.exp_lat; e.e0 = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("resp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int w0, r0;

        vecs.push_back(mk("sw_10",   1, W,  32'h10, 32'h11223344, 4'b1111, 32'h0, 0, 1));
        vecs.push_back(mk("lw_10",   0, W,  32'h10, 32'h0, 4'b0000, 32'h11223344, 0, 2));
        vecs.push_back(mk("sb_13",   1, B,  32'h13, 32'h00000080, 4'b1000, 32'h0, 0, 1));
        vecs.push_back(mk("lb_13",   0, B,  32'h13, 32'h0, 4'b0000, 32'hFFFFFF80, 0, 2));
        vecs.push_back(mk("lbu_13",  0, BU, 32'h13, 32'h0, 4'b0000, 32'h00000080, 0, 2));
        vecs.push_back(mk("sh_21",   1, H,  32'h21, 32'h0000BEEF, 4'b0110, 32'h0, 0, 1));
        vecs.push_back(mk("lhu_21",  0, HU, 32'h21, 32'h0, 4'b0000, 32'h0000BEEF, 0, 2));
        vecs.push_back(mk("lh_21",   0, H,  32'h21, 32'h0, 4'b0000, 32'hFFFFBEEF, 0, 2));
        vecs.push_back(mk("lh_12",   0, H,  32'h12, 32'h0, 4'b0000, 32'hFFFF8022, 0, 2));
        vecs.push_back(mk("sb_11",   1, B,  32'h11, 32'hFFFFFF5A, 4'b0010, 32'h0, 0, 1));
        vecs.push_back(mk("lw_10b",  0, W,  32'h10, 32'h0, 4'b0000, 32'h80225A44, 0, 2));
        vecs.push_back(mk("lbu_11",  0, BU, 32'h11, 32'h0, 4'b0000, 32'h0000005A, 0, 2));
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
        vecs.push_back(mk("sw_2e",   1, W,  32'h2E, 32'hAABBCCDD, 4'b1100, 32'h0, 0, 2));
        vecs.push_back(mk("lw_2e",   0, W,  32'h2E, 32'h0, 4'b0000, 32'hAABBCCDD, 0, 3));
        vecs.push_back(mk("sh_27",   1, H,  32'h27, 32'h00009234, 4'b1000, 32'h0, 0, 2));
        vecs.push_back(mk("lh_27",   0, H,  32'h27, 32'h0, 4'b0000, 32'hFFFF9234, 0, 3));
        vecs.push_back(mk("lhu_27",  0, HU, 32'h27, 32'h0, 4'b0000, 32'h00009234, 0, 3));
`else
        vecs.push_back(mk("sw_2e",   1, W,  32'h2E, 32'hAABBCCDD, 4'b0000, 32'h0, 1, 1));
        vecs.push_back(mk("lw_2e",   0, W,  32'h2E, 32'h0, 4'b0000, 32'h0, 1, 1));
        vecs.push_back(mk("sh_27",   1, H,  32'h27, 32'h00009234, 4'b0000, 32'h0, 1, 1));
        vecs.push_back(mk("lh_27",   0, H,  32'h27, 32'h0, 4'b0000, 32'h0, 1, 1));
`endif

        // Reset values, with a store request held to show ram_we is gated.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_funct3 = W;
        req_addr  = 32'h10;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_fault", {31'h0, misalign_fault}, 32'd0);
        check("rst_ram_we", {28'h0, ram_we}, 32'h0);
        req_valid = 1'b0;
        req_we    = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            issue(vecs[i]);
            drain();
        end

`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
        check("mem_b_hi", {16'h0, mem[11][31:16]}, 32'h0000CCDD);
        check("mem_c_lo", {16'h0, mem[12][15:0]}, 32'h0000AABB);
        check("mem_9_b3", {24'h0, mem[9][31:24]}, 32'h00000034);
        check("mem_a_b0", {24'h0, mem[10][7:0]}, 32'h00000092);
`else
        w0 = wr_cnt;
        issue(mk("sw_35", 1, W, 32'h35, 32'h12345678, 4'b0000, 32'h0, 1, 1));
        drain();
        check("fault_no_write", 32'(wr_cnt), 32'(w0));
`endif

        // Back-to-back: a load accepted in the store's response cycle.
        issue(mk("b2b_sw", 1, W, 32'h30, 32'hCAFEF00D, 4'b1111, 32'h0, 0, 1));
        check("b2b_ready", {31'h0, req_ready}, 32'd1);
        check("b2b_resp", {31'h0, resp_valid}, 32'd1);
        issue(mk("b2b_lw", 0, W, 32'h30, 32'h0, 4'b0000, 32'hCAFEF00D, 0, 2));
        drain();

        // Reset in the middle of a load: no response may ever appear.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = W;
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
        req_addr   = 32'h2E;
`else
        req_addr   = 32'h10;
`endif
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("midop_busy", {31'h0, req_ready}, 32'd0);
        r0 = resp_cnt;
        rst = 1'b1;
        #1;
        check("midop_rst_ready", {31'h0, req_ready}, 32'd1);
        check("midop_rst_resp", {31'h0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midop_no_resp", 32'(resp_cnt), 32'(r0));
        @(posedge clk);
        #1;
        issue(mk("post_rst_lw", 0, W, 32'h10, 32'h0, 4'b0000, 32'h80225A44, 0, 2));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
